// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch stage.
// Default reset vector, PC increment, word width and decode bubble encoding.
package fetch_pkg;

    localparam int unsigned INSTR_W_DEF  = 32;
    localparam int unsigned PC_STEP_DEF  = 4;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    // addi x0, x0, 0: what decode inserts when no instruction is available
    localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_tag_fifo.sv
// Prefetch queue of PC-tagged instruction slots.
// Slots are allocated on issue, filled in order by responses, popped by decode.
module fetch_tag_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned INSTR_W = INSTR_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      alloc,
    input  logic [ADDR_W-1:0]         alloc_pc,
    input  logic                      fill,
    input  logic [INSTR_W-1:0]        fill_data,
    input  logic                      pop,
    output logic [$clog2(DEPTH):0]    count,
    output logic [$clog2(DEPTH):0]    unfilled,
    output logic                      head_filled,
    output logic [ADDR_W-1:0]         head_pc,
    output logic [INSTR_W-1:0]        head_instr
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [ADDR_W-1:0]  pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [DEPTH-1:0]   filled;
    logic [PW-1:0]      head;
    logic [PW-1:0]      tail;
    logic [PW-1:0]      fptr;

    // Pointer, occupancy and filled-flag bookkeeping; flush empties the queue
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head     <= '0;
            tail     <= '0;
            fptr     <= '0;
            count    <= '0;
            unfilled <= '0;
            filled   <= '0;
        end else begin
            if (alloc) begin
                filled[tail] <= 1'b0;
                tail         <= tail + PW'(1);
            end
            if (fill) begin
                filled[fptr] <= 1'b1;
                fptr         <= fptr + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            count    <= count + CW'(alloc) - CW'(pop);
            unfilled <= unfilled + CW'(alloc) - CW'(fill);
        end
    end

    // Slot payload storage; alloc and fill never target the same slot
    always_ff @(posedge clk) begin
        if (alloc) begin
            pc_mem[tail]    <= alloc_pc;
            instr_mem[tail] <= '0;
        end
        if (fill) begin
            instr_mem[fptr] <= fill_data;
        end
    end

    assign head_filled = (count != '0) && filled[head];
    assign head_pc     = (count != '0) ? pc_mem[head] : '0;
    assign head_instr  = (count != '0) ? instr_mem[head] : '0;

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage: PC, in-order read issue and prefetch buffering.
// Redirects flush the queue; responses still in flight are counted and dropped.
module fetch_queue_unit
    import fetch_pkg::*;
#(
    parameter int unsigned      ADDR_W     = 32,
    parameter int unsigned      INSTR_W    = INSTR_W_DEF,
    parameter int unsigned      PC_STEP    = PC_STEP_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(RESET_PC_DEF),
    parameter int unsigned      FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_addr,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [ADDR_W-1:0]  mem_req_addr,
    input  logic               mem_resp_valid,
    input  logic [INSTR_W-1:0] mem_resp_data,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [ADDR_W-1:0] pc;
    logic [CW-1:0]     drop_cnt;
    logic [CW-1:0]     count;
    logic [CW-1:0]     unfilled;
    logic              issue;
    logic              fill;
    logic              pop;
    logic              resp_err;

    assign mem_req_valid = ~rst & ~redirect_valid & (count < CW'(FIFO_DEPTH));
    assign mem_req_addr  = pc;
    assign issue         = mem_req_valid & mem_req_ready;

    assign fill = mem_resp_valid & ~rst & ~redirect_valid
                & (drop_cnt == '0) & (unfilled != '0);
    assign pop  = if_valid & if_ready & ~redirect_valid & ~rst;

    // A response with nothing outstanding to match it
    assign resp_err = mem_resp_valid & ~rst
                    & (drop_cnt == '0) & (unfilled == '0);

    fetch_tag_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush       (redirect_valid),
        .alloc       (issue),
        .alloc_pc    (pc),
        .fill        (fill),
        .fill_data   (mem_resp_data),
        .pop         (pop),
        .count       (count),
        .unfilled    (unfilled),
        .head_filled (if_valid),
        .head_pc     (if_pc),
        .head_instr  (if_instr)
    );

    // PC advances on each accepted request; redirect loads the target
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_addr;
        end else if (issue) begin
            pc <= pc + ADDR_W'(PC_STEP);
        end
    end

    // Count responses still owed to flushed slots and swallow them
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            if (resp_err) begin
                drop_cnt <= '0;
            end else begin
                drop_cnt <= drop_cnt + unfilled - CW'(mem_resp_valid);
            end
        end else if (mem_resp_valid && (drop_cnt != '0)) begin
            drop_cnt <= drop_cnt - CW'(1);
        end
    end

    // Unmatched responses are ignored by the datapath but flagged here
    always_ff @(posedge clk) begin
        assert (!resp_err);
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: directed scenarios plus random traffic.
// Reference model tracks fetch epochs and the expected slot list.
module tb_fetch_queue_unit;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_addr = '0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    always #5 clk = ~clk;

    fetch_queue_unit #(
        .ADDR_W     (32),
        .INSTR_W    (32),
        .PC_STEP    (4),
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          ep;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        bit          filled;
    } ent_t;

    mreq_t pend[$];
    ent_t  expq[$];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          lat_lo = 1;
    int          lat_hi = 1;
    int          stall_pct = 0;
    logic [31:0] model_pc = RESET_PC;

    bit          drv_redir = 0;
    bit          drv_req_ready = 0;
    bit          drv_if_ready = 0;
    logic [31:0] drv_target = '0;

    logic        obs_req_valid, obs_if_valid, obs_hs, obs_pop;
    logic [31:0] obs_req_addr, obs_if_pc, obs_if_instr;
    logic        exp_req_valid, exp_if_valid, exp_head_known;
    logic [31:0] exp_req_addr, exp_if_pc, exp_if_instr;

    function automatic logic [31:0] img(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // One clock: drive inputs, sample outputs, advance model and memory
    task automatic step();
        bit marked;
        @(negedge clk);
        redirect_valid = drv_redir;
        redirect_addr  = drv_target;
        mem_req_ready  = drv_req_ready;
        if_ready       = drv_if_ready;
        mem_resp_valid = (pend.size() > 0) && (pend[0].due <= cyc)
                       && ($urandom_range(99) >= stall_pct);
        mem_resp_data  = mem_resp_valid ? img(pend[0].addr) : $urandom;
        #1;
        obs_req_valid = mem_req_valid;
        obs_req_addr  = mem_req_addr;
        obs_if_valid  = if_valid;
        obs_if_pc     = if_pc;
        obs_if_instr  = if_instr;
        obs_hs        = obs_req_valid && drv_req_ready;
        obs_pop       = obs_if_valid && drv_if_ready && !drv_redir;

        exp_req_valid  = !drv_redir && (expq.size() < DEPTH);
        exp_req_addr   = model_pc;
        exp_if_valid   = (expq.size() > 0) && expq[0].filled;
        exp_if_pc      = exp_if_valid ? expq[0].pc : 32'h0;
        exp_if_instr   = exp_if_valid ? img(expq[0].pc) : 32'h0;
        exp_head_known = exp_if_valid || (expq.size() == 0);

        if (drv_redir) begin
            expq.delete();
            model_pc = drv_target;
            epoch++;
        end else begin
            if (mem_resp_valid && pend[0].ep == epoch) begin
                marked = 0;
                for (int i = 0; i < expq.size(); i++) begin
                    if (!marked && !expq[i].filled) begin
                        expq[i].filled = 1;
                        marked = 1;
                    end
                end
            end
            if (exp_if_valid && drv_if_ready) expq.delete(0);
            if (exp_req_valid && drv_req_ready) begin
                expq.push_back('{pc: model_pc, filled: 1'b0});
                model_pc = model_pc + 32'd4;
            end
        end
        if (mem_resp_valid) pend.delete(0);
        if (obs_hs)
            pend.push_back('{addr: obs_req_addr,
                             due: cyc + $urandom_range(lat_hi, lat_lo),
                             ep: epoch});
        @(posedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; redirect_valid = 0; mem_req_ready = 0;
        if_ready = 0; mem_resp_valid = 0;
        drv_redir = 0; drv_req_ready = 0; drv_if_ready = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        pend.delete(); expq.delete();
        model_pc = RESET_PC;
        epoch++;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (mem_req_valid !== 1'b0) begin
            errors++; $display("FAIL reset_req_valid: got %b want 0", mem_req_valid);
        end
        checks++;
        if (if_valid !== 1'b0) begin
            errors++; $display("FAIL reset_if_valid: got %b want 0", if_valid);
        end
        checks++;
        if (if_pc !== 32'h0) begin
            errors++; $display("FAIL reset_if_pc: got %h want 0", if_pc);
        end
        checks++;
        if (if_instr !== 32'h0) begin
            errors++; $display("FAIL reset_if_instr: got %h want 0", if_instr);
        end
        rst = 0;
        pend.delete(); expq.delete();
        model_pc = RESET_PC;
        step();
        checks++;
        if (obs_req_addr !== RESET_PC) begin
            errors++; $display("FAIL reset_pc: got %h want %h", obs_req_addr, RESET_PC);
        end
        checks++;
        if (obs_if_valid !== 1'b0) begin
            errors++; $display("FAIL reset_if_valid_after: got %b want 0", obs_if_valid);
        end
    endtask

    task automatic test_stream();
        int hs_n = 0;
        int pop_n = 0;
        drv_req_ready = 1; drv_if_ready = 1; drv_redir = 0;
        lat_lo = 1; lat_hi = 1; stall_pct = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (obs_hs) begin
                checks++;
                if (obs_req_addr !== 32'(hs_n * 4)) begin
                    errors++;
                    $display("FAIL stream_req_addr: got %h want %h", obs_req_addr, hs_n * 4);
                end
                hs_n++;
            end
            if (obs_pop) begin
                checks++;
                if (obs_if_pc !== 32'(pop_n * 4) || obs_if_instr !== img(32'(pop_n * 4))) begin
                    errors++;
                    $display("FAIL stream_pop: got pc %h instr %h want pc %h instr %h",
                             obs_if_pc, obs_if_instr, pop_n * 4, img(32'(pop_n * 4)));
                end
                pop_n++;
            end
            if (i >= 2) begin
                checks++;
                if (obs_if_valid !== 1'b1) begin
                    errors++; $display("FAIL stream_if_valid: cycle %0d got %b want 1", i, obs_if_valid);
                end
            end
        end
        checks++;
        if (pop_n != 18) begin
            errors++; $display("FAIL stream_pop_count: got %0d want 18", pop_n);
        end
    endtask

    task automatic test_full();
        int hs_n = 0;
        int pop_n = 0;
        bit saw_hs = 0;
        do_reset();
        drv_req_ready = 1; drv_if_ready = 0;
        lat_lo = 1; lat_hi = 1; stall_pct = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (obs_hs) begin
                checks++;
                if (obs_req_addr !== 32'(hs_n * 4)) begin
                    errors++;
                    $display("FAIL full_req_addr: got %h want %h", obs_req_addr, hs_n * 4);
                end
                hs_n++;
            end
        end
        checks++;
        if (hs_n != 4) begin
            errors++; $display("FAIL full_req_count: got %0d want 4", hs_n);
        end
        checks++;
        if (obs_req_valid !== 1'b0) begin
            errors++; $display("FAIL full_req_valid: got %b want 0", obs_req_valid);
        end
        drv_if_ready = 1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (obs_pop && pop_n < 4) begin
                checks++;
                if (obs_if_pc !== 32'(pop_n * 4) || obs_if_instr !== img(32'(pop_n * 4))) begin
                    errors++;
                    $display("FAIL full_pop: got pc %h want %h", obs_if_pc, pop_n * 4);
                end
            end
            if (obs_pop) pop_n++;
            if (obs_hs && !saw_hs) begin
                checks++;
                if (obs_req_addr !== 32'h10) begin
                    errors++; $display("FAIL full_resume_addr: got %h want 00000010", obs_req_addr);
                end
                saw_hs = 1;
            end
        end
        checks++;
        if (pop_n < 4 || !saw_hs) begin
            errors++; $display("FAIL full_drain: pops %0d resumed %0d want >=4 and 1", pop_n, saw_hs);
        end
    endtask

    task automatic test_redirect_drop();
        bit saw_hs = 0;
        bit saw_pop = 0;
        do_reset();
        lat_lo = 3; lat_hi = 3; stall_pct = 0;
        drv_if_ready = 1; drv_req_ready = 1;
        step();
        step();
        checks++;
        if (!obs_hs || obs_req_addr !== 32'h4) begin
            errors++; $display("FAIL drop_second_req: hs %b addr %h want 1 00000004", obs_hs, obs_req_addr);
        end
        drv_req_ready = 0; drv_redir = 1; drv_target = 32'h100;
        step();
        checks++;
        if (obs_req_valid !== 1'b0) begin
            errors++; $display("FAIL drop_req_during_redirect: got %b want 0", obs_req_valid);
        end
        drv_redir = 0; drv_req_ready = 1;
        for (int i = 0; i < 30 && !saw_pop; i++) begin
            step();
            checks++;
            if (obs_if_valid !== exp_if_valid) begin
                errors++; $display("FAIL drop_if_valid: got %b want %b", obs_if_valid, exp_if_valid);
            end
            if (obs_hs && !saw_hs) begin
                checks++;
                if (obs_req_addr !== 32'h100) begin
                    errors++; $display("FAIL drop_first_req: got %h want 00000100", obs_req_addr);
                end
                saw_hs = 1;
            end
            if (obs_pop) begin
                checks++;
                if (obs_if_pc !== 32'h100 || obs_if_instr !== img(32'h100)) begin
                    errors++;
                    $display("FAIL drop_first_pop: got pc %h instr %h want pc 00000100 instr %h",
                             obs_if_pc, obs_if_instr, img(32'h100));
                end
                saw_pop = 1;
            end
        end
        checks++;
        if (!saw_pop) begin
            errors++; $display("FAIL drop_timeout: got no pop want pop of 00000100");
        end
    endtask

    task automatic test_redirect_same_resp();
        bit saw_hs = 0;
        bit saw_pop = 0;
        do_reset();
        lat_lo = 2; lat_hi = 2; stall_pct = 0;
        drv_if_ready = 1; drv_req_ready = 1;
        step();
        drv_req_ready = 0;
        step();
        drv_redir = 1; drv_target = 32'h200;
        step();
        checks++;
        if (mem_resp_valid !== 1'b1 || obs_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL same_resp_setup: resp %b req_valid %b want 1 0", mem_resp_valid, obs_req_valid);
        end
        drv_redir = 0; drv_req_ready = 1;
        for (int i = 0; i < 30 && !saw_pop; i++) begin
            step();
            checks++;
            if (obs_if_valid !== exp_if_valid) begin
                errors++; $display("FAIL same_resp_if_valid: got %b want %b", obs_if_valid, exp_if_valid);
            end
            if (obs_hs && !saw_hs) begin
                checks++;
                if (obs_req_addr !== 32'h200) begin
                    errors++; $display("FAIL same_resp_first_req: got %h want 00000200", obs_req_addr);
                end
                saw_hs = 1;
            end
            if (obs_pop) begin
                checks++;
                if (obs_if_pc !== 32'h200 || obs_if_instr !== img(32'h200)) begin
                    errors++; $display("FAIL same_resp_first_pop: got pc %h want 00000200", obs_if_pc);
                end
                saw_pop = 1;
            end
        end
        checks++;
        if (!saw_pop) begin
            errors++; $display("FAIL same_resp_timeout: got no pop want pop of 00000200");
        end
    endtask

    task automatic test_wrap();
        int hs_n = 0;
        int pop_n = 0;
        logic [31:0] want;
        do_reset();
        lat_lo = 1; lat_hi = 1; stall_pct = 0;
        drv_if_ready = 1; drv_req_ready = 1;
        repeat (3) step();
        drv_redir = 1; drv_target = 32'hFFFF_FFFC;
        step();
        drv_redir = 0;
        for (int i = 0; i < 20 && pop_n < 2; i++) begin
            step();
            if (obs_hs && hs_n < 2) begin
                want = (hs_n == 0) ? 32'hFFFF_FFFC : 32'h0;
                checks++;
                if (obs_req_addr !== want) begin
                    errors++; $display("FAIL wrap_req: got %h want %h", obs_req_addr, want);
                end
                hs_n++;
            end
            if (obs_pop) begin
                want = (pop_n == 0) ? 32'hFFFF_FFFC : 32'h0;
                checks++;
                if (obs_if_pc !== want || obs_if_instr !== img(want)) begin
                    errors++; $display("FAIL wrap_pop: got pc %h want %h", obs_if_pc, want);
                end
                pop_n++;
            end
        end
        checks++;
        if (pop_n != 2) begin
            errors++; $display("FAIL wrap_timeout: got %0d pops want 2", pop_n);
        end
    endtask

    task automatic test_midreset();
        do_reset();
        lat_lo = 1; lat_hi = 1; stall_pct = 0;
        drv_if_ready = 0; drv_req_ready = 1;
        repeat (3) step();
        step();
        checks++;
        if (obs_if_valid !== 1'b1 || obs_if_pc !== 32'h0) begin
            errors++; $display("FAIL midrst_setup: if_valid %b pc %h want 1 00000000", obs_if_valid, obs_if_pc);
        end
        do_reset();
        step();
        checks++;
        if (obs_if_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_if_valid: got %b want 0", obs_if_valid);
        end
        checks++;
        if (obs_req_addr !== RESET_PC || obs_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_req: addr %h valid %b want %h 1", obs_req_addr, obs_req_valid, RESET_PC);
        end
    endtask

    task automatic test_random();
        do_reset();
        lat_lo = 1; lat_hi = 4; stall_pct = 20;
        for (int i = 0; i < 800; i++) begin
            drv_req_ready = ($urandom_range(3) != 0);
            drv_if_ready  = ($urandom_range(2) != 0);
            drv_redir     = ($urandom_range(24) == 0) && (pend.size() <= DEPTH);
            drv_target    = ($urandom_range(7) == 0) ? 32'hFFFF_FFF8
                                                     : ($urandom & 32'h0000_FFFC);
            step();
            checks++;
            if (obs_req_valid !== exp_req_valid) begin
                errors++; $display("FAIL rand_req_valid: cycle %0d got %b want %b", i, obs_req_valid, exp_req_valid);
            end
            if (exp_req_valid) begin
                checks++;
                if (obs_req_addr !== exp_req_addr) begin
                    errors++; $display("FAIL rand_req_addr: cycle %0d got %h want %h", i, obs_req_addr, exp_req_addr);
                end
            end
            checks++;
            if (obs_if_valid !== exp_if_valid) begin
                errors++; $display("FAIL rand_if_valid: cycle %0d got %b want %b", i, obs_if_valid, exp_if_valid);
            end
            if (exp_head_known) begin
                checks++;
                if (obs_if_pc !== exp_if_pc || obs_if_instr !== exp_if_instr) begin
                    errors++;
                    $display("FAIL rand_head: cycle %0d got pc %h instr %h want pc %h instr %h",
                             i, obs_if_pc, obs_if_instr, exp_if_pc, exp_if_instr);
                end
            end
        end
        drv_redir = 0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_redirect_drop();
        test_redirect_same_resp();
        test_wrap();
        test_midreset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
Parametrised next-generation instruction fetch stage for the pipeline processor. Holds the PC, issues in-order instruction reads to a variable-latency memory port with valid/ready handshake, and buffers returned instructions, each tagged with its PC, in a FIFO_DEPTH-entry prefetch queue. Feeds decode through a valid/ready interface. A redirect (jump/branch) flushes the queue and discards in-flight responses.

Parameters:
ADDR_W, 32, PC and memory address width
INSTR_W, 32, instruction width
PC_STEP, 4, sequential PC increment in bytes
RESET_PC, 0, PC value loaded on reset
FIFO_DEPTH, 4, prefetch queue entries; power of 2, >=2; also caps outstanding reads

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
redirect_valid  in  1  load redirect_addr into PC, flush queue
redirect_addr  in  ADDR_W  jump target
mem_req_valid  out  1  read request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  ADDR_W  read address (current PC)
mem_resp_valid  in  1  read data valid; responses return in request order
mem_resp_data  in  INSTR_W  instruction word
if_valid  out  1  head entry filled and available to decode
if_ready  in  1  decode consumes head entry
if_instr  out  INSTR_W  head instruction
if_pc  out  ADDR_W  PC of head instruction

Behaviour:
- Reset: PC=RESET_PC, queue empty, drop_cnt=0; mem_req_valid=0, if_valid=0, if_instr=0, if_pc=0 in the first cycle after reset. Reset overrides every other input, including mid-transaction; responses arriving after reset for pre-reset requests are memory's responsibility (memory is reset together).
- Queue entry = {pc, instr, filled}. Issue allocates an entry at tail with pc=PC, filled=0. A response fills the oldest unfilled entry (fill pointer). Head pops when if_valid & if_ready.
- mem_req_valid = ~rst & ~redirect_valid & (count < FIFO_DEPTH). mem_req_addr = PC. Issue handshake (valid & ready): allocate entry, PC <= PC + PC_STEP, modulo 2^ADDR_W (wraps silently).
- mem_req_valid, once raised, holds its address stable until accepted or a redirect occurs.
- Full: count == FIFO_DEPTH -> no request. Simultaneous pop and issue on a full queue is not allowed (mem_req_valid is evaluated from registered count); pop and issue in the same cycle below full keeps count unchanged.
- if_valid = head entry exists & filled; if_instr/if_pc driven from head entry, 0 when empty. Minimum latency: request accepted cycle N, response cycle N+k, if_valid in cycle N+k+1 (registered fill).
- Redirect (redirect_valid=1): PC <= redirect_addr; all entries invalidated; no pop takes effect (if_ready ignored that cycle); drop_cnt <= drop_cnt + (unfilled entries) - (mem_resp_valid ? 1 : 0). No request is issued during a redirect cycle, so no handshake overlaps it. The first request to redirect_addr is issued in the next cycle.
- While drop_cnt > 0, each mem_resp_valid decrements drop_cnt and data is discarded; no entry is filled.
- A response arriving with no unfilled entry and drop_cnt = 0 is a protocol error; it is ignored, and a simulation assertion fires.
- Back-to-back redirects: each recomputes drop_cnt from the current state; the last target wins.
- drop_cnt width: clog2(FIFO_DEPTH)+1. It never exceeds FIFO_DEPTH, because outstanding reads are bounded by the queue size.

Decomposition:
- Shared package (fetch_pkg): RESET_PC default, PC_STEP default, instruction-word width constant, NOP encoding used by decode on bubble.
- One sub-module: fetch_tag_fifo, the FIFO_DEPTH-entry queue with separate alloc/fill/pop pointers, filled bits, flush input and unfilled-count output. The top level holds the PC, request logic and drop counter.

Test Plan:
- Reset then mem_req_ready=1, 1-cycle memory, if_ready=1 -> requests at 0x0,0x4,0x8,...; if_pc/if_instr stream matches the memory image in order, one per cycle after fill.
- if_ready=0, FIFO_DEPTH=4 -> exactly 4 requests (0x0..0xC), then mem_req_valid=0. Raise if_ready -> 4 pops in order, then requests resume at 0x10.
- 3-cycle latency with 2 outstanding reads (0x0, 0x4), redirect_addr=0x100 -> both stale responses dropped (drop_cnt 2->0), next request 0x100, first if_pc=0x100.
- Redirect in the same cycle as a stale mem_resp_valid, with 1 unfilled entry -> drop_cnt stays 0, no entry filled, next request is the target.
- PC=0xFFFFFFFC, ADDR_W=32 -> next request address 0x00000000.
- rst asserted mid-stream with 2 filled entries -> next cycle if_valid=0, mem_req_addr=RESET_PC, count=0.
